// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: word-organised data memory serving byte/half/word loads and stores with fixed latency
// Ports: clk, rst (async, active high); memRead/memWrite/funct3/addr/writeData request from the pipeline;
//        readData extended load result; stall holds the pipeline; done/fault one-cycle completion pulses.
module data_mem_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       writeData,
  output logic [31:0]       readData,
  output logic              stall,
  output logic              done,
  output logic              fault
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [2:0]    f3_q, f3_d;
  logic [31:0]   wd_q, wd_d;
  logic          wr_q, wr_d;
  logic          fault_q, fault_d;
  logic [31:0]   rd_q, rd_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic        req, illegal, commit;
  logic [4:0]  sh;
  logic [31:0] word, lane, mask, ext, merged;
  logic        unused_addr;

  assign unused_addr = ^addr[ADDR_W-1:AW+2];

  always_comb begin
    req     = memRead | memWrite;
    // half/word alignment is checked on the low funct3 bits; bad size codes are caught separately
    illegal = (memRead & memWrite)
            | (memRead & (funct3 == 3'b011 | funct3[2:1] == 2'b11))
            | (memWrite & (funct3[2] | funct3 == 3'b011))
            | (funct3[1:0] == 2'b01 & addr[0])
            | (funct3[1:0] == 2'b10 & addr[1:0] != 2'b00);
    commit  = state_q == ACCESS && cnt_q == '0;
    // halfword accesses are aligned, so byte offset * 8 also gives the half-lane shift
    sh      = {addr_q[1:0], 3'b000};
    word    = mem[addr_q[AW+1:2]];
    lane    = word >> sh;
    ext     = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & lane[7]}}, lane[7:0]} :
              f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & lane[15]}}, lane[15:0]} : lane;
    mask    = (f3_q[1:0] == 2'b00 ? 32'h0000_00FF :
               f3_q[1:0] == 2'b01 ? 32'h0000_FFFF : 32'hFFFF_FFFF) << sh;
    merged  = (word & ~mask) | ((wd_q << sh) & mask);
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    wd_d    = wd_q;
    wr_d    = wr_q;
    fault_d = fault_q;
    rd_d    = commit & ~wr_q ? ext : rd_q;
    if (state_q == IDLE && req) begin
      state_d = illegal ? DONE : ACCESS;
      fault_d = illegal;
      cnt_d   = CW'(LATENCY - 1);
      addr_d  = addr[AW+1:0];
      f3_d    = funct3;
      wd_d    = writeData;
      wr_d    = memWrite;
    end else if (state_q == ACCESS) begin
      state_d = commit ? DONE : ACCESS;
      cnt_d   = commit ? cnt_q : cnt_q - 1'b1;
    end else if (state_q == DONE) begin
      state_d = IDLE;
      fault_d = 1'b0;
    end
    stall    = (state_q == IDLE & req) | (state_q == ACCESS);
    done     = state_q == DONE;
    fault    = state_q == DONE & fault_q;
    readData = rd_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      f3_q    <= '0;
      wd_q    <= '0;
      wr_q    <= 1'b0;
      fault_q <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      wd_q    <= wd_d;
      wr_q    <= wr_d;
      fault_q <= fault_d;
      rd_q    <= rd_d;
    end
  end

  // array is not reset; a reset forces IDLE so an in-flight store never commits
  always_ff @(posedge clk) begin
    if (commit & wr_q) mem[addr_q[AW+1:2]] <= merged;
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed checks of data_mem_ctrl loads, stores, faults, wrap and reset abort
module tb_data_mem_ctrl;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memRead = 1'b0;
  logic        memWrite = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] writeData = '0;
  logic [31:0] readData;
  logic        stall, done, fault;
  int checks = 0;
  int failures = 0;

  data_mem_ctrl #(.ADDR_W(32), .DEPTH_WORDS(256), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite), .funct3(funct3),
    .addr(addr), .writeData(writeData), .readData(readData), .stall(stall),
    .done(done), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic req(string tag, logic r, logic w, logic [2:0] f, logic [31:0] a,
                     logic [31:0] d, bit bad, logic [31:0] exp_rd);
    memRead = r; memWrite = w; funct3 = f; addr = a; writeData = d;
    #1;
    chk({tag, ":stall_accept"}, {31'd0, stall}, 32'd1);
    chk({tag, ":done_accept"}, {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    memRead = 1'b0; memWrite = 1'b0;
    if (!bad) begin
      for (int i = 0; i < LAT; i++) begin
        chk({tag, ":stall_access"}, {31'd0, stall}, 32'd1);
        chk({tag, ":done_access"}, {31'd0, done}, 32'd0);
        @(posedge clk); #1;
      end
    end
    chk({tag, ":done"}, {31'd0, done}, 32'd1);
    chk({tag, ":fault"}, {31'd0, fault}, {31'd0, bad});
    chk({tag, ":stall_done"}, {31'd0, stall}, 32'd0);
    chk({tag, ":readData"}, readData, exp_rd);
    @(posedge clk); #1;
    chk({tag, ":done_clear"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    #12;
    chk("rst_readData", readData, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("idle_readData", readData, 32'd0);
      chk("idle_stall", {31'd0, stall}, 32'd0);
      chk("idle_done", {31'd0, done}, 32'd0);
      chk("idle_fault", {31'd0, fault}, 32'd0);
    end
    req("sw_10",  1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    req("lw_10",  1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
    req("sb_11",  1'b0, 1'b1, 3'b000, 32'h11, 32'h000000A5, 1'b0, 32'hDEADBEEF);
    req("lw_10b", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEADA5EF);
    req("lb_11",  1'b1, 1'b0, 3'b000, 32'h11, 32'h0, 1'b0, 32'hFFFFFFA5);
    req("lbu_11", 1'b1, 1'b0, 3'b100, 32'h11, 32'h0, 1'b0, 32'h000000A5);
    req("lh_12",  1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 32'hFFFFDEAD);
    req("lhu_12", 1'b1, 1'b0, 3'b101, 32'h12, 32'h0, 1'b0, 32'h0000DEAD);
    req("lhu_10", 1'b1, 1'b0, 3'b101, 32'h10, 32'h0, 1'b0, 32'h0000A5EF);
    req("sh_16",  1'b0, 1'b1, 3'b001, 32'h16, 32'h00007F01, 1'b0, 32'h0000A5EF);
    req("lw_14",  1'b1, 1'b0, 3'b010, 32'h14, 32'h0, 1'b0, 32'h7F01_0000 | 32'h0);
    req("sw_400", 1'b0, 1'b1, 3'b010, 32'h400, 32'h12345678, 1'b0, 32'h7F010000);
    req("lw_0",   1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 32'h12345678);
    req("bad_lw13",  1'b1, 1'b0, 3'b010, 32'h13, 32'h0, 1'b1, 32'h12345678);
    req("bad_sh01",  1'b0, 1'b1, 3'b001, 32'h01, 32'hFFFFFFFF, 1'b1, 32'h12345678);
    req("bad_ld011", 1'b1, 1'b0, 3'b011, 32'h0, 32'h0, 1'b1, 32'h12345678);
    req("bad_sb100", 1'b0, 1'b1, 3'b100, 32'h0, 32'hFFFFFFFF, 1'b1, 32'h12345678);
    req("bad_both",  1'b1, 1'b1, 3'b010, 32'h10, 32'hFFFFFFFF, 1'b1, 32'h12345678);
    req("lw_0_after", 1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 32'h12345678);
    req("lw_10_after", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEADA5EF);
    req("sw_20",  1'b0, 1'b1, 3'b010, 32'h20, 32'h11112222, 1'b0, 32'hDEADA5EF);
    memWrite = 1'b1; funct3 = 3'b010; addr = 32'h20; writeData = 32'h55AA55AA;
    @(posedge clk); #1;
    memWrite = 1'b0;
    chk("abort_stall_pre", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_readData", readData, 32'd0);
    chk("abort_stall", {31'd0, stall}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_fault", {31'd0, fault}, 32'd0);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_idle_stall", {31'd0, stall}, 32'd0);
    chk("abort_idle_done", {31'd0, done}, 32'd0);
    req("lw_20", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'h11112222);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Data-memory responder that consumes the memRead/memWrite strobes produced by the control decoder, together with the ALU address, rs2 store data and funct3.
- Performs byte, halfword or word loads and stores against an internal word-organised memory with a configurable access latency.
- Holds the pipeline with stall while an access is in flight.
- Signals completion with a one-cycle done pulse; load data is returned sign- or zero-extended.

Parameters:
ADDR_W, 32, width of addr input
DEPTH_WORDS, 256, number of 32-bit words in the array; power of two, at least 2
LATENCY, 2, cycles spent in ACCESS state; at least 1

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
memRead  in  1  load request from control decoder
memWrite  in  1  store request from control decoder
funct3  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
addr  in  ADDR_W  byte address from the ALU
writeData  in  32  store data (rs2)
readData  out  32  extended load result, held until the next successful load
stall  out  1  pipeline hold
done  out  1  one-cycle completion pulse
fault  out  1  one-cycle error pulse, coincident with done

Behaviour:
- Reset (async, rst=1): state=IDLE, counter=0, readData=0, done=0, fault=0. Latched request fields are cleared. Memory contents are NOT reset. A reset during ACCESS aborts the operation; a store that has not yet committed is dropped.
- States: IDLE, ACCESS, DONE.
- req = memRead | memWrite.
- stall = (state==IDLE & req) | (state==ACCESS). It is combinational from the inputs in IDLE and is 0 in DONE.
- IDLE with req=1, legal request: latch addr, funct3, writeData and op; counter=LATENCY-1; go to ACCESS.
- IDLE with req=1, illegal request: go directly to DONE with fault flagged. There is no memory access and readData is unchanged. A request is illegal if any of the following holds:
  - memRead and memWrite are both 1;
  - a load with funct3 in {011, 110, 111};
  - a store with funct3 not in {000, 001, 010};
  - a halfword access with addr[0]=1;
  - a word access with addr[1:0]!=00.
- ACCESS: decrement the counter each cycle. On the cycle the counter reads 0:
  - stores commit to the array at that clock edge;
  - loads capture the extended data into readData at that edge;
  - then go to DONE.
- DONE: done=1 for exactly one cycle, with fault=1 if the request was illegal. Then go to IDLE unconditionally. Inputs are ignored in DONE; the pipeline advances on this cycle.
- Latency: request accepted in cycle T; ACCESS occupies T+1..T+LATENCY; done is high in T+LATENCY+1. A fault request has done in T+1.
- Word index = addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Lane selection is little-endian:
  - byte lane = addr[1:0];
  - half lane = addr[1];
  - SB/SH merge writeData[7:0] or writeData[15:0] into the selected lane and leave the other bytes unchanged.
- Load extension:
  - LB/LH replicate bit 7 or bit 15 of the selected lane;
  - LBU/LHU zero-fill;
  - LW returns the full word.
- A store updates readData never. A successful load overwrites readData.
- Back-to-back: a new request is accepted only in IDLE, so at most one access is accepted every LATENCY+2 cycles.

Test Plan:
- Reset then idle, no req: readData=0, stall=0, done=0, fault=0 throughout.
- SW addr=0x10 data=0xDEADBEEF, then LW 0x10 (LATENCY=2): stall high in cycles T..T+2, done in T+3, fault=0; the load returns readData=0xDEADBEEF.
- With word 0x10 = 0xDEADBEEF: SB 0x11 data=0x000000A5, then LW 0x10 -> 0xDEADA5EF. Then LB 0x11 -> 0xFFFFFFA5, LBU 0x11 -> 0x000000A5, LH 0x12 -> 0xFFFFDEAD, LHU 0x12 -> 0x0000DEAD.
- With DEPTH_WORDS=256: SW addr=0x400 data=0x12345678, then LW 0x0 -> 0x12345678 (address wrap).
- Illegal requests each return done=fault=1 one cycle after accept with memory and readData unchanged:
  - LW 0x13;
  - SH 0x01;
  - load funct3=011;
  - memRead=memWrite=1.
- SW 0x20 data=0x55AA55AA, with rst pulsed on the first ACCESS cycle: all outputs return to 0 immediately. A subsequent LW 0x20 returns the prior contents, not 0x55AA55AA.
